// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch controller
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam int         PC_INC     = 4;
    localparam logic [1:0] FIFO_DEPTH = 2'd2;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO of {pc, instruction} with flush and simultaneous push+pop
// Ports: clk, reset (sync, active-high); push_i/pop_i/flush_i controls; data_i write word;
//        valid_o head present, full_o two entries held, data_o head word (0 when empty), count_o occupancy.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic         full_o,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic [1:0]   count_q, count_d;
    logic         rd_q, rd_d, wr_q, wr_d;

    always_comb begin
        count_d = count_q + 2'(push_i) - 2'(pop_i);
        rd_d    = rd_q ^ pop_i;
        wr_d    = wr_q ^ push_i;
    end

    // flush shares the reset path so a redirect leaves the buffer exactly as after reset
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            count_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !reset && !flush_i)
            mem_q[wr_q] <= data_i;
    end

    assign valid_o = count_q != 2'd0;
    assign full_o  = count_q == FIFO_DEPTH;
    assign data_o  = valid_o ? mem_q[rd_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_controller.sv
// instruction_fetch_controller: owns the fetch PC, reads the combinational ROM and buffers words for decode
// Ports: clk, reset (sync, active-high); mem_address/mem_instruction ROM interface;
//        redirect_valid/redirect_pc branch-jump target; inst_valid/inst_ready/inst_data/inst_pc decode
//        handshake; fetch_fault sticky out-of-range or misaligned flag.
// Option: define FETCH_BYPASS_EN to hand the ROM word straight to decode when the buffer is empty.
module instruction_fetch_controller
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 1024,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_instruction,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [DATA_WIDTH-1:0] inst_pc,
    output logic                  fetch_fault
);

    localparam logic [DATA_WIDTH-1:0] PC_LIMIT = DATA_WIDTH'(MEMORY_DEPTH * 4);
    localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(PC_INC);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic                    in_range, run_ok, push, pop, bypass, advance;
    logic                    fifo_valid, fifo_full;
    logic [2*DATA_WIDTH-1:0] fifo_head;
    logic [1:0]              fifo_count;

    // an overflowed PC wraps to a small value but is caught here only if it is also misaligned
    // or beyond the ROM; a wrapped aligned PC inside the ROM is a legitimate fetch
    assign in_range = fetch_pc_q[1:0] == 2'b00 && fetch_pc_q < PC_LIMIT;
    assign run_ok   = state_q == RUN && in_range && !redirect_valid;
    assign pop      = fifo_valid && inst_ready;

`ifdef FETCH_BYPASS_EN
    assign bypass     = run_ok && !fifo_valid && inst_ready;
    assign inst_valid = fifo_valid || bypass;
    assign inst_data  = bypass ? mem_instruction : fifo_head[DATA_WIDTH-1:0];
    assign inst_pc    = bypass ? fetch_pc_q : fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];
`else
    assign bypass     = 1'b0;
    assign inst_valid = fifo_valid;
    assign inst_data  = fifo_head[DATA_WIDTH-1:0];
    assign inst_pc    = fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];
`endif

    // a full buffer still accepts a word when decode frees the head in the same cycle
    assign push    = run_ok && !bypass && (!fifo_full || pop);
    assign advance = push || bypass;

    always_comb begin
        state_d    = (state_q == BOOT || redirect_valid) ? RUN
                   : (state_q == RUN && !in_range)       ? FAULT
                   : state_q;
        fetch_pc_d = redirect_valid ? redirect_pc
                   : advance        ? fetch_pc_q + PC_STEP
                   : fetch_pc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(.W(2 * DATA_WIDTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_i  ({fetch_pc_q, mem_instruction}),
        .valid_o (fifo_valid),
        .full_o  (fifo_full),
        .data_o  (fifo_head),
        .count_o (fifo_count)
    );

    logic unused_count;
    assign unused_count = ^fifo_count;

    assign mem_address = fetch_pc_q;
    assign fetch_fault = state_q == FAULT;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// tb_instruction_fetch_controller: queue-based model compared every cycle plus directed literal checks
module tb_instruction_fetch_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_address, mem_instruction, redirect_pc = '0, inst_data, inst_pc;
    logic        redirect_valid = 1'b0, inst_valid, inst_ready = 1'b1, fetch_fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq_pc[$], mq_data[$], consumed[$];
    logic [31:0] m_pc = '0;
    bit          m_init = 0, m_started = 0, m_fault = 0;

    instruction_fetch_controller dut (
        .clk             (clk),
        .reset           (reset),
        .mem_address     (mem_address),
        .mem_instruction (mem_instruction),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a >= 32'd4096) return 32'hDEADBEEF;
        if (a == 32'd0) return 32'h20080005;
        if (a == 32'd4) return 32'h20090003;
        return {16'h2400, a[15:0]};
    endfunction

    assign mem_instruction = rom(mem_address);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // fetch model: a PC, a two-slot queue of delivered-later words, and a fault flag
    initial forever begin
        bit pop, full;
        @(posedge clk);
        if (reset) begin
            mq_pc.delete(); mq_data.delete();
            m_pc = '0; m_started = 0; m_fault = 0; m_init = 1;
        end else begin
            full = mq_pc.size() == 2;
            pop  = mq_pc.size() != 0 && inst_ready;
            if (pop) begin
                consumed.push_back(mq_pc[0]);
                void'(mq_pc.pop_front());
                void'(mq_data.pop_front());
            end
            if (redirect_valid) begin
                mq_pc.delete(); mq_data.delete();
                m_pc = redirect_pc; m_fault = 0; m_started = 1;
            end else if (!m_started) begin
                m_started = 1;
            end else if (!m_fault) begin
                if (m_pc % 4 == 0 && m_pc < 32'd4096) begin
                    if (!full || pop) begin
                        mq_pc.push_back(m_pc);
                        mq_data.push_back(rom(m_pc));
                        m_pc = m_pc + 32'd4;
                    end
                end else begin
                    m_fault = 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_init) begin
            chk("model_valid", {31'd0, inst_valid}, {31'd0, mq_pc.size() != 0});
            chk("model_pc", inst_pc, mq_pc.size() != 0 ? mq_pc[0] : 32'd0);
            chk("model_data", inst_data, mq_data.size() != 0 ? mq_data[0] : 32'd0);
            chk("model_addr", mem_address, m_pc);
            chk("model_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        // reset state and first-fetch latency
        step(2);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_addr", mem_address, 32'h0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rst_data", inst_data, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        reset = 1'b0;
        step(1);
        chk("boot_valid", {31'd0, inst_valid}, 32'd0);
        step(1);
        chk("first_valid", {31'd0, inst_valid}, 32'd1);
        chk("first_pc", inst_pc, 32'h0);
        chk("first_data", inst_data, 32'h20080005);
        step(1);
        chk("second_pc", inst_pc, 32'h4);
        chk("second_data", inst_data, 32'h20090003);

        // back-pressure: buffer saturates at two, then drains without gaps
        inst_ready = 1'b0;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(5);
        chk("stall_addr", mem_address, 32'h8);
        chk("stall_head", inst_pc, 32'h0);
        consumed.delete();
        inst_ready = 1'b1;
        step(1);
        chk("drain_pc1", inst_pc, 32'h4);
        step(1);
        chk("drain_pc2", inst_pc, 32'h8);
        step(1);
        chk("drain_pc3", inst_pc, 32'hC);
        chk("drain_n", consumed.size(), 32'd3);
        chk("drain_0", consumed[0], 32'h0);
        chk("drain_1", consumed[1], 32'h4);
        chk("drain_2", consumed[2], 32'h8);

        // redirect with two buffered entries flushes them
        inst_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step(1);
        redirect_valid = 1'b0;
        chk("flush_valid", {31'd0, inst_valid}, 32'd0);
        chk("flush_addr", mem_address, 32'h40);
        step(1);
        chk("redir_valid", {31'd0, inst_valid}, 32'd1);
        chk("redir_pc", inst_pc, 32'h40);
        chk("redir_data", inst_data, 32'h24000040);
        chk("flushed_unseen", consumed.size(), 32'd3);

        // run off the end of the ROM, then recover by redirect
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFF0;
        step(1);
        redirect_valid = 1'b0;
        step(6);
        chk("end_fault", {31'd0, fetch_fault}, 32'd1);
        chk("end_addr", mem_address, 32'h1000);
        chk("end_valid", {31'd0, inst_valid}, 32'd0);
        chk("end_last", consumed[$], 32'hFFC);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        step(1);
        redirect_valid = 1'b0;
        chk("recover_fault", {31'd0, fetch_fault}, 32'd0);
        step(1);
        chk("recover_valid", {31'd0, inst_valid}, 32'd1);
        chk("recover_pc", inst_pc, 32'h0);

        // misaligned target
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        step(1);
        redirect_valid = 1'b0;
        chk("mis_fault0", {31'd0, fetch_fault}, 32'd0);
        chk("mis_valid0", {31'd0, inst_valid}, 32'd0);
        step(1);
        chk("mis_fault1", {31'd0, fetch_fault}, 32'd1);
        chk("mis_valid1", {31'd0, inst_valid}, 32'd0);
        step(1);
        chk("mis_valid2", {31'd0, inst_valid}, 32'd0);

        // reset beats a simultaneous redirect with a full buffer
        inst_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        step(1);
        redirect_valid = 1'b0;
        step(3);
        chk("pre_rst_pc", inst_pc, 32'h0);
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        step(1);
        reset = 1'b0;
        redirect_valid = 1'b0;
        chk("rr_valid", {31'd0, inst_valid}, 32'd0);
        chk("rr_addr", mem_address, 32'h0);
        chk("rr_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rr_data", inst_data, 32'h0);
        step(1);
        chk("rr_boot_valid", {31'd0, inst_valid}, 32'd0);
        chk("rr_boot_addr", mem_address, 32'h0);
        step(1);
        chk("rr_run_valid", {31'd0, inst_valid}, 32'd1);
        chk("rr_run_pc", inst_pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
